// File: rtl/ref_window_linebuf_pkg.sv
// ref_window_linebuf_pkg: default geometry and helpers for the reference-window line buffer
package ref_window_linebuf_pkg;
  localparam int PIX_W_DEF        = 8;
  localparam int PIX_PER_WORD_DEF = 8;
  localparam int DEPTH_DEF        = 23;
  localparam int NUM_BANKS_DEF    = 4;
  localparam int OUT_PIX_DEF      = 23;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/ref_window_linebuf_if.sv
// ref_window_linebuf_if: input beat handshake and window-column output bundle
interface ref_window_linebuf_if import ref_window_linebuf_pkg::*; #(
  parameter int PIX_W        = PIX_W_DEF,
  parameter int PIX_PER_WORD = PIX_PER_WORD_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int NUM_BANKS    = NUM_BANKS_DEF,
  parameter int OUT_PIX      = OUT_PIX_DEF
);
  localparam int ADDR_W = clog2(DEPTH);
  logic                          clear;
  logic                          in_valid;
  logic                          in_ready;
  logic [PIX_PER_WORD*PIX_W-1:0] in_data;
  logic                          out_valid;
  logic [OUT_PIX*PIX_W-1:0]      out_data;
  logic [ADDR_W-1:0]             out_row;
  logic                          win_ready;
  logic [NUM_BANKS-1:0]          wr_bank;
  modport master (
    output clear, in_valid, in_data,
    input  in_ready, out_valid, out_data, out_row, win_ready, wr_bank
  );
  modport slave (
    input  clear, in_valid, in_data,
    output in_ready, out_valid, out_data, out_row, win_ready, wr_bank
  );
endinterface

// File: rtl/ref_window_linebuf_sram.sv
// ref_window_linebuf_sram: single-port bank, registered Q, 1-cycle read; behavioural stand-in for the foundry macro
module ref_window_linebuf_sram #(
  parameter int DEPTH  = 23,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  d_i,
  output logic [WIDTH-1:0]  q_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= d_i;
      else q_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/ref_window_linebuf.sv
// ref_window_linebuf: rotating row buffer; each beat writes the active bank and reads the
// same address from the others, emitting a vertical window column oldest row first.
module ref_window_linebuf import ref_window_linebuf_pkg::*; #(
  parameter int PIX_W        = PIX_W_DEF,
  parameter int PIX_PER_WORD = PIX_PER_WORD_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int NUM_BANKS    = NUM_BANKS_DEF,
  parameter int OUT_PIX      = OUT_PIX_DEF
) (
  input logic                 clk,
  input logic                 rst,
  ref_window_linebuf_if.slave bus
);
  localparam int ADDR_W = clog2(DEPTH);
  localparam int WORD_W = PIX_PER_WORD * PIX_W;
  localparam int WIN_W  = (NUM_BANKS - 1) * WORD_W;
  localparam int OUT_W  = OUT_PIX * PIX_W;
  logic [ADDR_W-1:0]    addr_q, out_row_q;
  logic [NUM_BANKS-1:0] wr_bank_q, wr_bank_d, sel_q;
  logic                 win_ready_q, out_valid_q, accept, last;
  logic [WORD_W-1:0]    q [NUM_BANKS];
  logic [WIN_W-1:0]     win;
  assign accept    = bus.in_valid & ~bus.clear;
  assign last      = addr_q == ADDR_W'(DEPTH - 1);
  assign wr_bank_d = last ? {wr_bank_q[NUM_BANKS-2:0], wr_bank_q[NUM_BANKS-1]} : wr_bank_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q      <= '0;
      wr_bank_q   <= NUM_BANKS'(1);
      sel_q       <= NUM_BANKS'(1);
      win_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
    end else if (bus.clear) begin
      addr_q      <= '0;
      wr_bank_q   <= NUM_BANKS'(1);
      sel_q       <= NUM_BANKS'(1);
      win_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
    end else begin
      out_valid_q <= accept & win_ready_q;
      if (accept) begin
        out_row_q <= addr_q;
        sel_q     <= wr_bank_q;
        addr_q    <= last ? '0 : addr_q + 1'b1;
        wr_bank_q <= wr_bank_d;
        if (wr_bank_d[NUM_BANKS-1]) win_ready_q <= 1'b1;
      end
    end
  for (genvar g = 0; g < NUM_BANKS; g++) begin : gen_bank
    ref_window_linebuf_sram #(.DEPTH(DEPTH), .WIDTH(WORD_W), .ADDR_W(ADDR_W)) u_bank (
      .clk    (clk),
      .en_i   (accept),
      .we_i   (wr_bank_q[g]),
      .addr_i (addr_q),
      .d_i    (bus.in_data),
      .q_o    (q[g])
    );
  end
  // slot j (from the top) holds bank w+j, so the oldest resident row lands in the MSBs
  always_comb begin
    win = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int j = 1; j < NUM_BANKS; j++)
        if (sel_q[b]) win[WIN_W-j*WORD_W +: WORD_W] = q[(b+j)%NUM_BANKS];
  end
  assign bus.in_ready  = ~bus.clear;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = OUT_W'(win >> (WIN_W - OUT_W));
  assign bus.out_row   = out_row_q;
  assign bus.win_ready = win_ready_q;
  assign bus.wr_bank   = wr_bank_q;
endmodule

// File: tb/tb_ref_window_linebuf.sv
// tb_ref_window_linebuf: directed beats with a bank-array model feeding a scoreboard;
// a negedge monitor pops and compares every window column the DUT presents.
module tb_ref_window_linebuf;
  localparam int PIX_W = 8, PPW = 8, DEPTH = 23, NB = 4, OUT_PIX = 23;
  localparam int ADDR_W = 5, WORD_W = PPW * PIX_W, WIN_W = (NB - 1) * WORD_W, OUT_W = OUT_PIX * PIX_W;
  typedef struct {
    logic [OUT_W-1:0]  data;
    logic [ADDR_W-1:0] row;
    int                cyc;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  exp_t sb[$];
  logic [WORD_W-1:0] mem [NB][DEPTH];
  int m_addr = 0, m_bank = 0, cyc = 0, total = 0, bad = 0, n = 0, last_row;
  bit m_win = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ref_window_linebuf_if #(.PIX_W(PIX_W), .PIX_PER_WORD(PPW), .DEPTH(DEPTH), .NUM_BANKS(NB), .OUT_PIX(OUT_PIX)) bus ();
  ref_window_linebuf #(.PIX_W(PIX_W), .PIX_PER_WORD(PPW), .DEPTH(DEPTH), .NUM_BANKS(NB), .OUT_PIX(OUT_PIX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  task automatic chk(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask
  task automatic m_reset();
    m_addr = 0;
    m_bank = 0;
    m_win  = 0;
  endtask
  task automatic beat(input bit v);
    logic [WIN_W-1:0] w;
    @(negedge clk);
    bus.clear    = 1'b0;
    bus.in_valid = v;
    bus.in_data  = {PPW{n[7:0]}};
    if (v) begin
      if (m_win) begin
        w = '0;
        for (int j = 1; j < NB; j++) w = {w[WIN_W-WORD_W-1:0], mem[(m_bank+j)%NB][m_addr]};
        sb.push_back('{data: OUT_W'(w >> (WIN_W - OUT_W)), row: ADDR_W'(m_addr), cyc: cyc + 1});
      end
      mem[m_bank][m_addr] = {PPW{n[7:0]}};
      n++;
      if (m_addr == DEPTH - 1) begin
        m_addr = 0;
        m_bank = (m_bank + 1) % NB;
        if (m_bank == NB - 1) m_win = 1;
      end else m_addr++;
    end
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    bit want;
    exp_t e;
    if (!rst) begin
      want = sb.size() > 0 && sb[0].cyc == cyc;
      if (want || bus.out_valid) begin
        chk("out_valid", OUT_W'(bus.out_valid), OUT_W'(want));
        if (want) begin
          e = sb.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_row", OUT_W'(bus.out_row), OUT_W'(e.row));
        end
      end
    end
  end
  initial begin
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_win_ready", OUT_W'(bus.win_ready), 0);
    chk("rst_wr_bank", OUT_W'(bus.wr_bank), 1);
    chk("rst_out_valid", OUT_W'(bus.out_valid), 0);
    chk("rst_out_row", OUT_W'(bus.out_row), 0);
    chk("rst_in_ready", OUT_W'(bus.in_ready), 1);
    repeat (68) beat(1);
    chk("boot68_win_ready", OUT_W'(bus.win_ready), 0);
    beat(1);
    chk("boot69_win_ready", OUT_W'(bus.win_ready), 1);
    chk("boot69_wr_bank", OUT_W'(bus.wr_bank), 4'b1000);
    beat(1);
    chk("col70_data", bus.out_data, {{8{8'h00}}, {8{8'h17}}, {7{8'h2E}}});
    chk("col70_row", OUT_W'(bus.out_row), 0);
    repeat (21) beat(1);
    chk("wrap91_wr_bank", OUT_W'(bus.wr_bank), 4'b1000);
    beat(1);
    chk("wrap92_wr_bank", OUT_W'(bus.wr_bank), 4'b0001);
    beat(1);
    chk("col93_data", bus.out_data, {{8{8'h17}}, {8{8'h2E}}, {7{8'h45}}});
    chk("col93_row", OUT_W'(bus.out_row), 0);
    for (int i = 0; i < 8; i++) begin
      last_row = m_addr;
      beat(1);
      beat(0);
      chk("idle_out_valid", OUT_W'(bus.out_valid), 0);
      chk("idle_out_row", OUT_W'(bus.out_row), OUT_W'(last_row));
    end
    beat(1);
    @(negedge clk);
    bus.clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = '1;
    #1;
    chk("clear_in_ready", OUT_W'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    m_reset();
    chk("clear_win_ready", OUT_W'(bus.win_ready), 0);
    chk("clear_wr_bank", OUT_W'(bus.wr_bank), 1);
    chk("clear_out_valid", OUT_W'(bus.out_valid), 0);
    repeat (68) beat(1);
    chk("refill68_win_ready", OUT_W'(bus.win_ready), 0);
    beat(1);
    chk("refill69_win_ready", OUT_W'(bus.win_ready), 1);
    repeat (6) beat(1);
    #2;
    rst = 1'b1;
    sb.delete();
    m_reset();
    #1;
    chk("arst_out_valid", OUT_W'(bus.out_valid), 0);
    chk("arst_win_ready", OUT_W'(bus.win_ready), 0);
    chk("arst_wr_bank", OUT_W'(bus.wr_bank), 1);
    chk("arst_out_row", OUT_W'(bus.out_row), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (68) beat(1);
    chk("reboot68_win_ready", OUT_W'(bus.win_ready), 0);
    repeat (4) beat(1);
    chk("reboot72_win_ready", OUT_W'(bus.win_ready), 1);
    repeat (3) beat(0);
    chk("drain", OUT_W'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
